// File: rtl/key_capture_bank.sv
// Debounced push-button operand capture bank: parallel or channel-by-channel load.
// Optional long-press clear is built when KEY_CAPTURE_LONGPRESS_EN is defined.
module key_capture_bank #(
    parameter int CH              = 4,
    parameter int W               = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 64,
    parameter int PTR_W           = $clog2(CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              button,
    input  logic              mode,
    input  logic [CH*W-1:0]   din,
    output logic [CH*W-1:0]   dout,
    output logic [PTR_W-1:0]  ptr,
    output logic              full,
    output logic              press,
    output logic              long_press
);

    localparam int               DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(CH - 1);

    logic [1:0]      sync_r;
    logic            btn_s;
    logic            stable_r;
    logic [DB_W-1:0] db_cnt_r;
    logic            differ_s;
    logic            accept_s;
    logic            rise_s;
    logic            clear_s;

    assign btn_s = sync_r[1];

    // Two-flop synchroniser for the raw button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], button};
        end
    end

    // Debounce qualification and rising-edge detection of the accepted level
    always_comb begin
        differ_s = btn_s ^ stable_r;
        accept_s = 1'b0;
        rise_s   = 1'b0;
        if (differ_s && (db_cnt_r == DB_LAST)) begin
            accept_s = 1'b1;
            rise_s   = btn_s;
        end else begin
            accept_s = 1'b0;
            rise_s   = 1'b0;
        end
    end

    // Stable level and run-length counter; any agreeing sample restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_r <= 1'b0;
            db_cnt_r <= {DB_W{1'b0}};
        end else if (!differ_s) begin
            db_cnt_r <= {DB_W{1'b0}};
        end else if (accept_s) begin
            stable_r <= ~stable_r;
            db_cnt_r <= {DB_W{1'b0}};
        end else begin
            db_cnt_r <= db_cnt_r + DB_W'(1);
        end
    end

    // Registered one-cycle press pulse, aligned with the capture edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press <= 1'b0;
        end else begin
            press <= rise_s;
        end
    end

`ifdef KEY_CAPTURE_LONGPRESS_EN
    localparam int HC_W = $clog2(LONG_CYCLES + 1);

    logic [HC_W-1:0] hold_cnt_r;

    // Saturating at LONG_CYCLES is what limits the clear to once per hold
    always_comb begin
        if (stable_r && (hold_cnt_r == HC_W'(LONG_CYCLES - 1))) begin
            clear_s = 1'b1;
        end else begin
            clear_s = 1'b0;
        end
    end

    // Hold-length counter, active only while the accepted level is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_r <= {HC_W{1'b0}};
        end else if (!stable_r) begin
            hold_cnt_r <= {HC_W{1'b0}};
        end else if (hold_cnt_r != HC_W'(LONG_CYCLES)) begin
            hold_cnt_r <= hold_cnt_r + HC_W'(1);
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end

    // Registered long-press pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            long_press <= 1'b0;
        end else begin
            long_press <= clear_s;
        end
    end
`else
    assign clear_s    = 1'b0;
    assign long_press = 1'b0;
`endif

    // Operand capture: clear wins; rise_s and clear_s are mutually exclusive anyway
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= {(CH*W){1'b0}};
            ptr  <= {PTR_W{1'b0}};
            full <= 1'b0;
        end else if (clear_s) begin
            dout <= {(CH*W){1'b0}};
            ptr  <= {PTR_W{1'b0}};
            full <= 1'b0;
        end else if (rise_s) begin
            if (!mode) begin
                dout <= din;
                ptr  <= {PTR_W{1'b0}};
                full <= 1'b1;
            end else begin
                for (int i = 0; i < CH; i++) begin
                    if (ptr == PTR_W'(i)) begin
                        dout[i*W +: W] <= din[i*W +: W];
                    end
                end
                if (ptr == PTR_LAST) begin
                    ptr  <= {PTR_W{1'b0}};
                    full <= 1'b1;
                end else begin
                    ptr  <= ptr + PTR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_key_capture_bank.sv
// Scoreboard bench for key_capture_bank (CH=4, W=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=8).
module tb_key_capture_bank;

    localparam int D = 4;
    localparam int L = 8;

    typedef struct {
        logic [15:0] dout;
        logic [1:0]  ptr;
        logic        full;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        button = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] din = 16'h0000;
    logic [15:0] dout;
    logic [1:0]  ptr;
    logic        full;
    logic        press;
    logic        long_press;

    exp_t pq[$];
    exp_t lq[$];
    exp_t pe;
    exp_t le;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    key_capture_bank #(
        .CH(4), .W(4), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .PTR_W(2)
    ) dut (
        .clk(clk), .rst(rst), .button(button), .mode(mode), .din(din),
        .dout(dout), .ptr(ptr), .full(full), .press(press), .long_press(long_press)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a pulse
    always @(negedge clk) begin
        if (press) begin
            if (pq.size() == 0) begin
                chk("unexpected_press", 32'd1, 32'd0);
            end else begin
                pe = pq.pop_front();
                chk("press_cycle", pe.cyc, cyc);
                chk("press_dout", {16'h0, dout}, {16'h0, pe.dout});
                chk("press_ptr", {30'h0, ptr}, {30'h0, pe.ptr});
                chk("press_full", {31'h0, full}, {31'h0, pe.full});
            end
        end
        if (long_press) begin
            if (lq.size() == 0) begin
                chk("unexpected_long_press", 32'd1, 32'd0);
            end else begin
                le = lq.pop_front();
                chk("lp_cycle", le.cyc, cyc);
                chk("lp_dout", {16'h0, dout}, {16'h0, le.dout});
                chk("lp_ptr", {30'h0, ptr}, {30'h0, le.ptr});
                chk("lp_full", {31'h0, full}, {31'h0, le.full});
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Clean press; din/mode are scrambled after the press to prove they are ignored
    task automatic do_press(input logic m, input logic [15:0] d, input logic [15:0] ed,
                            input logic [1:0] ep, input logic ef, input int hold,
                            input logic expect_lp);
        @(negedge clk);
        mode   = m;
        din    = d;
        button = 1'b1;
        pq.push_back('{ed, ep, ef, cyc + D + 2});
        if (expect_lp) begin
            lq.push_back('{16'h0000, 2'd0, 1'b0, cyc + D + 2 + L});
        end
        repeat (hold) @(negedge clk);
        din    = ~d;
        mode   = ~m;
        button = 1'b0;
        repeat (D + 4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_dout", {16'h0, dout}, 32'h0);
        chk("rst_ptr", {30'h0, ptr}, 32'h0);
        chk("rst_full", {31'h0, full}, 32'h0);
        chk("rst_press", {31'h0, press}, 32'h0);
        chk("rst_long_press", {31'h0, long_press}, 32'h0);

        // Bounce: 2-cycle toggles never satisfy the debounce window
        din = 16'hBEEF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            button = ~button;
            @(negedge clk);
        end
        button = 1'b0;
        repeat (10) @(negedge clk);
        chk("bounce_dout", {16'h0, dout}, 32'h0);

        // Parallel load followed by a long hold
`ifdef KEY_CAPTURE_LONGPRESS_EN
        do_press(1'b0, 16'hA5C3, 16'hA5C3, 2'd0, 1'b1, 30, 1'b1);
        chk("hold_dout", {16'h0, dout}, 32'h0);
        chk("hold_full", {31'h0, full}, 32'h0);
`else
        do_press(1'b0, 16'hA5C3, 16'hA5C3, 2'd0, 1'b1, 30, 1'b0);
        chk("hold_dout", {16'h0, dout}, 32'h0000A5C3);
        chk("hold_full", {31'h0, full}, 32'h1);
`endif

        // Reset mid-debounce, button kept high through release
        @(negedge clk);
        mode   = 1'b0;
        din    = 16'h5A69;
        button = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_dout", {16'h0, dout}, 32'h0);
        pq.push_back('{16'h5A69, 2'd0, 1'b1, cyc + D + 2});
        repeat (D + 2) @(negedge clk);
        button = 1'b0;
        repeat (D + 4) @(negedge clk);
        chk("midrst_pending", pq.size(), 32'd0);

        // Sequential wrap
        do_reset();
        do_press(1'b1, 16'h1111, 16'h0001, 2'd1, 1'b0, D + 2, 1'b0);
        do_press(1'b1, 16'h2222, 16'h0021, 2'd2, 1'b0, D + 2, 1'b0);
        do_press(1'b1, 16'h3333, 16'h0321, 2'd3, 1'b0, D + 2, 1'b0);
        do_press(1'b1, 16'h4444, 16'h4321, 2'd0, 1'b1, D + 2, 1'b0);
        do_press(1'b1, 16'hFFFF, 16'h432F, 2'd1, 1'b1, D + 2, 1'b0);
        chk("seq_final_dout", {16'h0, dout}, 32'h0000432F);

        repeat (4) @(negedge clk);
        chk("press_queue_empty", pq.size(), 32'd0);
        chk("lp_queue_empty", lq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/key_capture_bank.md
# key_capture_bank

Parametrised operand-entry register bank for the board front panel. It debounces a push-button internally. On each qualified press it captures either all CH channels of W-bit switch data at once, or one channel per press in sequence. The registered result drives the display and the CPU operand inputs. It replaces the fixed four-by-four-bit button latch and is fully synchronous to clk. No derived clocks are used.

## Interface
Parameters:
- CH, 4: number of channels; must be ≥2.
- W, 4: bits per channel; must be ≥1.
- DEBOUNCE_CYCLES, 16: consecutive stable clk cycles needed to accept a button level change; must be ≥1. Board build uses 1_000_000.
- LONG_CYCLES, 64: hold length for long-press clear. Only used with KEY_CAPTURE_LONGPRESS_EN.
- PTR_W, $clog2(CH): channel pointer width.

Ports:
- clk, input, 1: system clock; all state changes on its rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- button, input, 1: raw asynchronous push-button, active-high, may bounce.
- mode, input, 1: 0 = parallel load, 1 = sequential load. Sampled only on the press cycle.
- din, input, CH*W: switch data; channel i is din[i*W +: W].
- dout, output, CH*W: captured data; channel i is dout[i*W +: W].
- ptr, output, PTR_W: next channel to be written in sequential mode.
- full, output, 1: every channel has been written since the last reset or clear.
- press, output, 1: one-cycle pulse marking an accepted press.
- long_press, output, 1: one-cycle pulse marking a long-press clear.

## Operation
Synchroniser:
- button passes through two flops to give btn_s.

Debounce:
- A stable level register and a counter are kept.
- While btn_s equals stable, the counter is held at 0.
- While btn_s differs from stable, the counter increments.
- When the counter reaches DEBOUNCE_CYCLES-1 with btn_s still different, stable toggles and the counter returns to 0.
- Any sample equal to stable clears the counter, so bounce restarts the count.

Press:
- A 0→1 transition of stable asserts press for exactly one cycle.
- A 1→0 transition has no effect.

Capture, on the edge where press asserts, with mode 0:
- dout is loaded from din.
- ptr becomes 0.
- full becomes 1.

Capture, on the edge where press asserts, with mode 1:
- Slot ptr of dout is loaded from din slot ptr; all other slots hold.
- If ptr = CH-1, ptr wraps to 0 and full is set; otherwise ptr increments.
- Once set, full stays 1 across wraps.

Other inputs:
- Changes to mode or din outside the press cycle have no effect.

Long press (macro enabled only):
- A hold counter runs while stable = 1 and clears when stable = 0.
- When the count reaches LONG_CYCLES, long_press pulses for one cycle.
- On that edge, dout, ptr and full are cleared.
- It fires at most once per hold.
- The press capture that began the hold has already taken effect.

## Timing
- Reset values: dout = 0, ptr = 0, full = 0, press = 0, long_press = 0. Synchroniser flops, stable and all counters are also 0.
- Press latency: button is first sampled high at edge E0 and held clean. stable, press and the new dout all appear after edge E0+DEBOUNCE_CYCLES+1.
- Release latency: the same length, DEBOUNCE_CYCLES+1 edges after the first low sample.
- Minimum spacing between presses: 2·(DEBOUNCE_CYCLES+1) cycles.
- Long press: long_press asserts LONG_CYCLES cycles after press. The clear is visible on the next output sample.
- Reset mid-debounce or mid-hold: all progress is discarded.
  - If button is held high through reset release, a full debounce runs and one press is generated.
- Clear versus press: a clear and a new press cannot coincide, because stable must fall and rise again first.

## Configuration
Macro: KEY_CAPTURE_LONGPRESS_EN.
- Defined: the hold counter and clear logic are present, with behaviour as above.
- Undefined:
  - No hold counter is built.
  - long_press is tied to 0.
  - LONG_CYCLES is ignored.
  - Holding the button has no effect beyond the single press.

## Test plan
Use CH=4, W=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=8 for all scenarios.
1. Reset and bounce: hold rst, then release. Outputs read dout=0, ptr=0, full=0. Toggle button every 2 cycles for 20 cycles, then hold it low. Required: press never asserts and dout stays 0.
2. Parallel load: mode=0, din=16'hA5C3, button clean high. Required: press is high for exactly one cycle, 5 edges after the first high sample. dout=16'hA5C3, full=1, ptr=0.
3. Sequential wrap: mode=1, with four presses presenting din=16'h1111, 16'h2222, 16'h3333, 16'h4444.
   - After each press, ptr reads 1, 2, 3, 0.
   - Final dout=16'h4321.
   - full goes from 0 to 1 only on the 4th press.
   - A 5th press with din=16'hFFFF gives dout=16'h432F and ptr=1.
4. Reset mid-debounce: button high for 2 cycles, pulse rst, keep button high. Required: press occurs 5 edges after rst deassertion, exactly once.
5. Long press, macro defined: after scenario 2, hold button. Required: long_press pulses once, 8 cycles after press, and dout=0, full=0. Continued holding produces no further pulse.
6. Long press, macro undefined: repeat scenario 5. Required: long_press stays 0 and dout remains 16'hA5C3.
